aludec_md: RTL and testbench
============================

# aludec_md

Parametrised ALU decoder with an integrated multiply/divide sequencer for the MIPS core. It extends the R-type decode to the full integer set (logic, shifts, unsigned compares) with a 4-bit ALU control. It adds HI/LO registers driven by an iterative WIDTH-cycle mult/multu/div/divu engine. It sits beside the main decoder in the execute path and asserts a stall so the PC and pipeline hold while HI/LO are not ready.

## Interface
- WIDTH, 32, datapath width. Operands, HI, LO and the iteration count all use it. Must be ≥ 4.
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- funct  in  6  funct field of the current instruction
- aluop  in  2  from main decoder: 00 add, 01 sub, 10 R-type, 11 slt (slti)
- srca  in  WIDTH  rs operand
- srcb  in  WIDTH  rt operand
- alucontrol  out  4  ALU operation select
- hilo_sel  out  1  instruction is mfhi/mflo; datapath muxes hilo_out to the result
- hilo_out  out  WIDTH  HI if funct=mfhi, else LO (combinational)
- stall  out  1  hold PC and instruction; the current instruction must not retire
- busy  out  1  sequencer in RUN
- illegal  out  1  aluop=10 and funct not in the decode list

## Operation
- alucontrol for aluop 00: 0010. For 01: 0110. For 11: 0111.
- alucontrol for aluop 10, by funct:
  - add 100000 / addu 100001: 0010
  - sub 100010 / subu 100011: 0110
  - and 100100: 0000
  - or 100101: 0001
  - xor 100110: 0011
  - nor 100111: 0100
  - slt 101010: 0111
  - sltu 101011: 1111
  - sll 000000: 1000
  - srl 000010: 1001
  - sra 000011: 1010
  - mfhi 010000, mthi 010001, mflo 010010, mtlo 010011, mult 011000, multu 011001, div 011010, divu 011011: 0010, with illegal=0
  - any other funct: 0010, illegal=1
- Muldiv class (all 8 funct codes above) applies only when aluop=10.
- FSM states: IDLE and RUN. A cycle counter cnt is log2(WIDTH)+1 bits wide.
- IDLE, with a mult/multu/div/divu present:
  - capture operands, op and signedness
  - load cnt=WIDTH-1 and go to RUN
  - the instruction retires in that cycle (stall=0)
- RUN:
  - one shift-add (mult) or restoring-subtract (div) step per cycle
  - cnt decrements each cycle
  - when cnt=0: write HI/LO at that edge and return to IDLE
- Signed ops:
  - operands converted to magnitude at issue
  - result sign fixed when HI/LO are written
  - quotient truncates toward zero; remainder takes the dividend's sign
- Multiply: HI = upper WIDTH bits, LO = lower WIDTH bits of the 2·WIDTH product.
- Divide: LO = quotient, HI = remainder.
- Divide by zero: LO = all ones, HI = srca as captured. No trap.
- Signed MIN / -1: LO = MIN, HI = 0.
- mthi/mtlo in IDLE: HI (resp. LO) ← srca at the edge.
- stall = busy & aluop=10 & (muldiv issue | mfhi | mflo | mthi | mtlo). All other instructions proceed while RUN continues.
- A stalled instruction is re-presented each cycle. It is accepted in the first cycle that busy=0.
- Operands are never re-sampled during RUN. Changes on srca/srcb do not affect the result in flight.

## Timing
- Reset values: state IDLE, cnt 0, HI 0, LO 0, busy 0, stall 0. alucontrol, illegal, hilo_sel and hilo_out follow the inputs combinationally from reset values.
- Reset asserted during RUN aborts the operation; HI/LO = 0 at that edge.
- Issue at edge E:
  - busy=1 for cycles E+1 … E+WIDTH
  - HI/LO updated at the edge ending cycle E+WIDTH
  - mfhi/mflo reads the new value in cycle E+WIDTH+1 with stall=0
  - total muldiv latency: WIDTH+1 cycles issue-to-readable
- Back-to-back muldiv: the second stalls through cycle E+WIDTH and issues at the edge ending E+WIDTH+1.
- An mfhi in the cycle HI is written: stalled (busy=1 in that cycle); it reads the new HI in the next cycle.
- alucontrol, hilo_sel and illegal are purely combinational: zero latency, independent of FSM state.

## Test plan
- ALU decode: sweep aluop 00/01/11, then every listed funct with aluop 10, plus funct 111111. Required: the mapped codes exactly; illegal=1 only for 111111.
- mult srca=0xFFFFFFFF, srcb=2 (signed). Required: busy for 32 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE. multu with the same operands: HI=0x00000001, LO=0xFFFFFFFE.
- div srca=-7, srcb=2. Required: LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). divu 7/0: LO=0xFFFFFFFF, HI=7. div 0x80000000 / -1: LO=0x80000000, HI=0.
- mflo issued 1 cycle after a mult. Required: stall=1 for exactly 31 cycles; the mflo result equals the product LO; an intervening add is not stalled.
- mthi 0x12345678, then mfhi. Required: hilo_out=0x12345678. mthi while busy: stalled until IDLE, and HI is then overwritten with the new value.
- Reset asserted at cycle 10 of a div. Required: next cycle busy=0, HI=LO=0, stall=0; a new div issued afterwards completes correctly.

Source files
------------

// File: rtl/aludec_md.sv
// aludec_md: ALU control decode plus HI/LO registers with an iterative mult/div sequencer and pipeline stall.
module aludec_md #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       funct,
  input  logic [1:0]       aluop,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic [3:0]       alucontrol,
  output logic             hilo_sel,
  output logic [WIDTH-1:0] hilo_out,
  output logic             stall,
  output logic             busy,
  output logic             illegal
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, nstate;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] hi, lo, p_hi, p_lo, b, ma, mb, nhi, nlo, fhi, flo;
  logic [WIDTH:0] sum, sh, dif;
  logic [2*WIDTH-1:0] prod;
  logic op_div, nq, nr, sa, sb, ge, md_cls, issue, mt;
  always_comb begin
    illegal = 1'b0;
    alucontrol = 4'b0010;
    case (aluop)
      2'b01: alucontrol = 4'b0110;
      2'b11: alucontrol = 4'b0111;
      2'b10:
        case (funct)
          6'b100000, 6'b100001: alucontrol = 4'b0010;
          6'b100010, 6'b100011: alucontrol = 4'b0110;
          6'b100100: alucontrol = 4'b0000;
          6'b100101: alucontrol = 4'b0001;
          6'b100110: alucontrol = 4'b0011;
          6'b100111: alucontrol = 4'b0100;
          6'b101010: alucontrol = 4'b0111;
          6'b101011: alucontrol = 4'b1111;
          6'b000000: alucontrol = 4'b1000;
          6'b000010: alucontrol = 4'b1001;
          6'b000011: alucontrol = 4'b1010;
          6'b010000, 6'b010001, 6'b010010, 6'b010011,
          6'b011000, 6'b011001, 6'b011010, 6'b011011: alucontrol = 4'b0010;
          default: illegal = 1'b1;
        endcase
      default: alucontrol = 4'b0010;
    endcase
  end
  // 0100xx are the HI/LO moves, 0110xx the mult/div issues
  assign md_cls   = (aluop == 2'b10) & (funct[5:4] == 2'b01) & ~funct[2];
  assign issue    = md_cls & funct[3] & ~busy;
  assign mt       = md_cls & ~funct[3] & funct[0] & ~busy;
  assign hilo_sel = (aluop == 2'b10) & (funct == 6'b010000 | funct == 6'b010010);
  assign hilo_out = (funct == 6'b010000) ? hi : lo;
  assign sa = ~funct[0] & srca[WIDTH-1];
  assign sb = ~funct[0] & srcb[WIDTH-1];
  assign ma = sa ? -srca : srca;
  assign mb = sb ? -srcb : srcb;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= nstate;
  always_comb nstate = (state == IDLE) ? (issue ? RUN : IDLE) : ((cnt == '0) ? IDLE : RUN);
  always_comb begin
    busy = state == RUN;
    stall = busy & md_cls;
  end
  // multiply: shift-add into {p_hi,p_lo}; divide: restoring, quotient shifts into p_lo
  assign sum  = {1'b0, p_hi} + (p_lo[0] ? {1'b0, b} : {(WIDTH+1){1'b0}});
  assign sh   = {p_hi, p_lo[WIDTH-1]};
  assign ge   = sh >= {1'b0, b};
  assign dif  = sh - {1'b0, b};
  assign nhi  = op_div ? (ge ? dif[WIDTH-1:0] : sh[WIDTH-1:0]) : sum[WIDTH:1];
  assign nlo  = op_div ? {p_lo[WIDTH-2:0], ge} : {sum[0], p_lo[WIDTH-1:1]};
  assign prod = nq ? -{nhi, nlo} : {nhi, nlo};
  assign fhi  = op_div ? (nr ? -nhi : nhi) : prod[2*WIDTH-1:WIDTH];
  assign flo  = op_div ? ((b == '0) ? '1 : (nq ? -nlo : nlo)) : prod[WIDTH-1:0];
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      p_hi <= '0;
      p_lo <= '0;
      b <= '0;
      op_div <= 1'b0;
      nq <= 1'b0;
      nr <= 1'b0;
    end else begin
      if (issue) begin
        cnt <= CW'(WIDTH - 1);
        op_div <= funct[1];
        nq <= sa ^ sb;
        nr <= sa;
        p_hi <= '0;
        p_lo <= funct[1] ? ma : mb;
        b <= funct[1] ? mb : ma;
      end else if (busy) begin
        cnt <= cnt - 1'b1;
        p_hi <= nhi;
        p_lo <= nlo;
        if (cnt == '0) begin
          hi <= fhi;
          lo <= flo;
        end
      end
      if (mt & funct[1]) lo <= srca;
      if (mt & ~funct[1]) hi <= srca;
    end
  end
endmodule

// File: tb/tb_aludec_md.sv
// tb_aludec_md: scoreboard bench for aludec_md; stimulus queues expectations, a negedge monitor checks them.
module tb_aludec_md;
  localparam int W = 32;
  logic clk = 0, reset;
  logic [5:0] funct;
  logic [1:0] aluop;
  logic [W-1:0] srca, srcb, hilo_out;
  logic [3:0] alucontrol;
  logic hilo_sel, stall, busy, illegal;
  int n_chk = 0, n_fail = 0;
  typedef struct {int sel; logic [31:0] exp; string name;} exp_t;
  exp_t sb[$];
  typedef struct {logic [1:0] op; logic [5:0] f; logic [3:0] ac; logic il; logic hs;} dec_t;
  dec_t tbl[25] = '{
    '{2'b00, 6'h00, 4'b0010, 1'b0, 1'b0}, '{2'b01, 6'h00, 4'b0110, 1'b0, 1'b0},
    '{2'b11, 6'h00, 4'b0111, 1'b0, 1'b0}, '{2'b10, 6'b100000, 4'b0010, 1'b0, 1'b0},
    '{2'b10, 6'b100001, 4'b0010, 1'b0, 1'b0}, '{2'b10, 6'b100010, 4'b0110, 1'b0, 1'b0},
    '{2'b10, 6'b100011, 4'b0110, 1'b0, 1'b0}, '{2'b10, 6'b100100, 4'b0000, 1'b0, 1'b0},
    '{2'b10, 6'b100101, 4'b0001, 1'b0, 1'b0}, '{2'b10, 6'b100110, 4'b0011, 1'b0, 1'b0},
    '{2'b10, 6'b100111, 4'b0100, 1'b0, 1'b0}, '{2'b10, 6'b101010, 4'b0111, 1'b0, 1'b0},
    '{2'b10, 6'b101011, 4'b1111, 1'b0, 1'b0}, '{2'b10, 6'b000000, 4'b1000, 1'b0, 1'b0},
    '{2'b10, 6'b000010, 4'b1001, 1'b0, 1'b0}, '{2'b10, 6'b000011, 4'b1010, 1'b0, 1'b0},
    '{2'b10, 6'b010000, 4'b0010, 1'b0, 1'b1}, '{2'b10, 6'b010001, 4'b0010, 1'b0, 1'b0},
    '{2'b10, 6'b010010, 4'b0010, 1'b0, 1'b1}, '{2'b10, 6'b010011, 4'b0010, 1'b0, 1'b0},
    '{2'b10, 6'b011000, 4'b0010, 1'b0, 1'b0}, '{2'b10, 6'b011001, 4'b0010, 1'b0, 1'b0},
    '{2'b10, 6'b011010, 4'b0010, 1'b0, 1'b0}, '{2'b10, 6'b011011, 4'b0010, 1'b0, 1'b0},
    '{2'b10, 6'b111111, 4'b0010, 1'b1, 1'b0}
  };
  localparam logic [5:0] MFHI = 6'b010000, MTHI = 6'b010001, MFLO = 6'b010010;
  localparam logic [5:0] MULT = 6'b011000, MULTU = 6'b011001, DIV = 6'b011010, DIVU = 6'b011011;
  localparam int S_AC = 0, S_IL = 1, S_HO = 2, S_BUSY = 3, S_STALL = 4, S_HS = 5;

  aludec_md #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .funct(funct), .aluop(aluop), .srca(srca), .srcb(srcb),
    .alucontrol(alucontrol), .hilo_sel(hilo_sel), .hilo_out(hilo_out), .stall(stall),
    .busy(busy), .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    n_chk++;
    n_fail++;
    $display("FAIL timeout: test did not finish at %0t", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  function automatic logic [31:0] get(int sel);
    case (sel)
      S_AC: return {28'd0, alucontrol};
      S_IL: return {31'd0, illegal};
      S_HO: return hilo_out;
      S_BUSY: return {31'd0, busy};
      S_STALL: return {31'd0, stall};
      default: return {31'd0, hilo_sel};
    endcase
  endfunction

  always @(negedge clk)
    while (sb.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = sb.pop_front();
      act = get(e.sel);
      n_chk++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h at %0t", e.name, act, e.exp, $time);
      end
    end

  task automatic expect_v(int sel, logic [31:0] exp, string name);
    sb.push_back('{sel, exp, name});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(logic [1:0] op, logic [5:0] f, logic [W-1:0] a, logic [W-1:0] bb);
    aluop = op;
    funct = f;
    srca = a;
    srcb = bb;
  endtask

  task automatic run_md(logic [5:0] f, logic [W-1:0] a, logic [W-1:0] bb,
                        logic [W-1:0] ehi, logic [W-1:0] elo, string nm);
    put(2'b10, f, a, bb);
    expect_v(S_STALL, 0, {nm, " issue stall"});
    expect_v(S_BUSY, 0, {nm, " issue busy"});
    cyc();
    for (int i = 0; i < W; i++) begin
      put(2'b00, 6'b100000, $urandom, $urandom);
      expect_v(S_BUSY, 1, {nm, " busy"});
      expect_v(S_STALL, 0, {nm, " add not stalled"});
      cyc();
    end
    put(2'b10, MFHI, 0, 0);
    expect_v(S_BUSY, 0, {nm, " done busy"});
    expect_v(S_STALL, 0, {nm, " mfhi stall"});
    expect_v(S_HS, 1, {nm, " hilo_sel"});
    expect_v(S_HO, ehi, {nm, " HI"});
    cyc();
    put(2'b10, MFLO, 0, 0);
    expect_v(S_HO, elo, {nm, " LO"});
    cyc();
  endtask

  initial begin
    reset = 1;
    put(2'b00, 6'h00, 0, 0);
    cyc();
    cyc();
    n_chk++;
    if (busy !== 1'b0 || stall !== 1'b0 || hilo_out !== '0) begin
      n_fail++;
      $display("FAIL reset state: busy %b stall %b hilo_out %h at %0t", busy, stall, hilo_out, $time);
    end
    expect_v(S_BUSY, 0, "reset busy");
    expect_v(S_STALL, 0, "reset stall");
    expect_v(S_HO, 0, "reset LO");
    cyc();
    funct = MFHI;
    expect_v(S_HO, 0, "reset HI");
    cyc();
    foreach (tbl[i]) begin
      put(tbl[i].op, tbl[i].f, 0, 0);
      expect_v(S_AC, {28'd0, tbl[i].ac}, $sformatf("alucontrol op%b f%b", tbl[i].op, tbl[i].f));
      expect_v(S_IL, {31'd0, tbl[i].il}, $sformatf("illegal op%b f%b", tbl[i].op, tbl[i].f));
      expect_v(S_HS, {31'd0, tbl[i].hs}, $sformatf("hilo_sel op%b f%b", tbl[i].op, tbl[i].f));
      cyc();
    end
    reset = 0;
    put(2'b00, 6'h00, 0, 0);
    cyc();
    run_md(MULT, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, "mult");
    run_md(MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, "multu");
    run_md(DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, "div -7/2");
    run_md(DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF, "divu 7/0");
    run_md(DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, "div min/-1");
    put(2'b10, MULT, 32'd3, 32'd5);
    cyc();
    put(2'b00, 6'b100000, 0, 0);
    expect_v(S_STALL, 0, "add after mult");
    cyc();
    for (int i = 0; i < W - 1; i++) begin
      put(2'b10, MFLO, $urandom, $urandom);
      expect_v(S_STALL, 1, "mflo stalled");
      cyc();
    end
    expect_v(S_STALL, 0, "mflo released");
    expect_v(S_HO, 32'd15, "mflo product");
    cyc();
    put(2'b10, MTHI, 32'h12345678, 0);
    cyc();
    put(2'b10, MFHI, 0, 0);
    expect_v(S_HO, 32'h12345678, "mthi idle");
    cyc();
    put(2'b10, MULTU, 32'd2, 32'd3);
    cyc();
    for (int i = 0; i < W; i++) begin
      put(2'b10, MTHI, 32'hCAFEBABE, 0);
      expect_v(S_STALL, 1, "mthi stalled");
      cyc();
    end
    expect_v(S_STALL, 0, "mthi released");
    cyc();
    put(2'b10, MFHI, 0, 0);
    expect_v(S_HO, 32'hCAFEBABE, "mthi after busy");
    cyc();
    put(2'b10, MFLO, 0, 0);
    expect_v(S_HO, 32'd6, "multu lo kept");
    cyc();
    put(2'b10, DIV, 32'd100, 32'd7);
    cyc();
    for (int i = 0; i < 9; i++) begin
      put(2'b00, 6'h20, 0, 0);
      cyc();
    end
    reset = 1;
    cyc();
    reset = 0;
    put(2'b10, MFHI, 0, 0);
    expect_v(S_BUSY, 0, "abort busy");
    expect_v(S_STALL, 0, "abort stall");
    expect_v(S_HO, 0, "abort HI");
    cyc();
    put(2'b10, MFLO, 0, 0);
    expect_v(S_HO, 0, "abort LO");
    cyc();
    run_md(DIV, 32'd100, 32'd7, 32'd2, 32'd14, "div 100/7");
    run_md(DIV, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2, "div -100/7");
    cyc();
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
